// File: rtl/faux_sata_hd_dma_engine.sv
// faux_sata_hd_dma_engine: SATA drive command layer model running DMA reads/writes as multi-burst transfers
module faux_sata_hd_dma_engine #(
    parameter int SECTOR_WORDS  = 128,
    parameter int BURST_SECTORS = 16,
    parameter int SLEEP_LENGTH  = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        transport_layer_ready,
    input  logic        h2d_reg_stb,
    input  logic        h2d_data_stb,
    input  logic        h2d_cmd_bit,
    input  logic [7:0]  h2d_command,
    input  logic [7:0]  h2d_control,
    input  logic [47:0] h2d_lba,
    input  logic [15:0] h2d_sector_count,
    input  logic        read_crc_fail,
    input  logic        remote_abort,
    input  logic        of_strobe,
    output logic        send_reg_stb,
    output logic        send_dma_act_stb,
    output logic        send_data_stb,
    output logic [11:0] data_fis_words,
    output logic [7:0]  d2h_status,
    output logic [7:0]  d2h_error,
    output logic [47:0] d2h_lba,
    output logic [15:0] d2h_sector_count,
    output logic [16:0] remaining,
    output logic [3:0]  cl_state,
    output logic        busy
);
    localparam logic [3:0] SLEEP_START = 4'd0;
    localparam logic [3:0] SEND_DIAG   = 4'd1;
    localparam logic [3:0] IDLE        = 4'd2;
    localparam logic [3:0] DMA_ACT     = 4'd3;
    localparam logic [3:0] WRITE_DATA  = 4'd4;
    localparam logic [3:0] READ_SEND   = 4'd5;
    localparam logic [3:0] READ_WAIT   = 4'd6;
    localparam logic [3:0] SEND_STATUS = 4'd7;

    logic [3:0]  state;
    logic [31:0] sleep_cnt, word_cnt, word_next, chunk_words;
    logic [16:0] chunk, load_count;
    logic        err, bad_cmd, crc_seen, crc_next, seen_low, is48, rd_cmd, wr_cmd;
    logic        unused_ctrl;

    assign unused_ctrl = ^{h2d_control[7:3], h2d_control[1:0]};
    assign cl_state    = state;
    assign busy        = state != IDLE;

    // burst sizing, host word counting and command decode
    always_comb begin
        chunk       = (remaining < 17'(BURST_SECTORS)) ? remaining : 17'(BURST_SECTORS);
        chunk_words = 32'(chunk) * 32'(SECTOR_WORDS);
        word_next   = word_cnt + {31'b0, of_strobe};
        crc_next    = crc_seen | read_crc_fail;
        is48        = h2d_command == 8'h25 || h2d_command == 8'h35;
        rd_cmd      = h2d_command == 8'h25 || h2d_command == 8'hC8;
        wr_cmd      = h2d_command == 8'h35 || h2d_command == 8'hCA;
        load_count  = is48 ? (h2d_sector_count == 16'd0 ? 17'h10000 : {1'b0, h2d_sector_count})
                           : (h2d_sector_count[7:0] == 8'd0 ? 17'd256 : {9'b0, h2d_sector_count[7:0]});
    end

    // command-layer FSM; soft reset overrides every transition
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= SLEEP_START;
            sleep_cnt        <= '0;
            word_cnt         <= '0;
            err              <= 1'b0;
            bad_cmd          <= 1'b0;
            crc_seen         <= 1'b0;
            seen_low         <= 1'b0;
            send_reg_stb     <= 1'b0;
            send_dma_act_stb <= 1'b0;
            send_data_stb    <= 1'b0;
            data_fis_words   <= '0;
            remaining        <= '0;
            d2h_status       <= 8'h50;
            d2h_error        <= 8'h01;
            d2h_lba          <= 48'd1;
            d2h_sector_count <= 16'd1;
        end else begin
            send_reg_stb     <= 1'b0;
            send_dma_act_stb <= 1'b0;
            send_data_stb    <= 1'b0;
            if (h2d_control[2]) begin
                state     <= SLEEP_START;
                sleep_cnt <= '0;
                remaining <= '0;
            end else begin
                case (state)
                    SLEEP_START: begin
                        sleep_cnt <= (sleep_cnt == 32'(SLEEP_LENGTH - 1)) ? '0 : sleep_cnt + 32'd1;
                        if (sleep_cnt == 32'(SLEEP_LENGTH - 1)) state <= SEND_DIAG;
                    end
                    SEND_DIAG: begin
                        send_reg_stb <= 1'b1;
                        d2h_status   <= 8'h50;
                        d2h_error    <= 8'h01;
                        state        <= IDLE;
                    end
                    IDLE: if (h2d_reg_stb && h2d_cmd_bit) begin
                        d2h_lba          <= h2d_lba;
                        d2h_sector_count <= h2d_sector_count;
                        err              <= 1'b0;
                        bad_cmd          <= !(rd_cmd || wr_cmd);
                        remaining        <= load_count;
                        state            <= rd_cmd ? READ_SEND : wr_cmd ? DMA_ACT : SEND_STATUS;
                    end
                    DMA_ACT: if (transport_layer_ready) begin
                        send_dma_act_stb <= 1'b1;
                        word_cnt         <= '0;
                        crc_seen         <= 1'b0;
                        state            <= WRITE_DATA;
                    end
                    WRITE_DATA: begin
                        word_cnt <= word_next;
                        crc_seen <= crc_next;
                        if (h2d_data_stb) begin
                            if (word_next != chunk_words || crc_next) begin
                                err   <= 1'b1;
                                state <= SEND_STATUS;
                            end else begin
                                remaining <= remaining - chunk;
                                state     <= (remaining == chunk) ? SEND_STATUS : DMA_ACT;
                            end
                        end
                    end
                    READ_SEND: if (transport_layer_ready) begin
                        send_data_stb  <= 1'b1;
                        data_fis_words <= chunk_words[11:0];
                        remaining      <= remaining - chunk;
                        seen_low       <= 1'b0;
                        state          <= READ_WAIT;
                    end
                    READ_WAIT: begin
                        if (remote_abort) begin
                            err   <= 1'b1;
                            state <= SEND_STATUS;
                        end else if (!transport_layer_ready) begin
                            seen_low <= 1'b1;
                        end else if (seen_low) begin
                            state <= (remaining == 17'd0) ? SEND_STATUS : READ_SEND;
                        end
                    end
                    SEND_STATUS: if (transport_layer_ready) begin
                        send_reg_stb <= 1'b1;
                        d2h_status   <= (err || bad_cmd) ? 8'h51 : 8'h50;
                        d2h_error    <= bad_cmd ? 8'h04 : err ? 8'h84 : 8'h00;
                        state        <= IDLE;
                    end
                    default: begin
                        state     <= SLEEP_START;
                        sleep_cnt <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/faux_sata_hd_dma_engine.md
Name: faux_sata_hd_dma_engine

Overview:
- Parametrised simulation model of a SATA drive command layer.
- Sits above the faux transport layer in the HD-side bench.
- Decodes host register FISes and executes READ/WRITE DMA (28- and 48-bit) as multi-burst transfers.
- Splits each transfer into data FISes of at most BURST_SECTORS sectors, counts host data words, and returns status. Reports error status on CRC failure, abort, word-count mismatch or an unknown command.

Parameters:
- SECTOR_WORDS, 128: 32-bit words per sector (power of two).
- BURST_SECTORS, 16: max sectors per data FIS / DMA activate (16 x 128 words = 8 KB).
- SLEEP_LENGTH, 100: cycles after reset before the diagnostic register FIS.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- transport_layer_ready  in  1  transport idle, can accept a send strobe
- h2d_reg_stb  in  1  host register FIS received (1 cycle)
- h2d_data_stb  in  1  host data FIS completed (1 cycle)
- h2d_cmd_bit  in  1  C bit of register FIS
- h2d_command  in  8  command code
- h2d_control  in  8  control; bit 2 = SRST
- h2d_lba  in  48  start LBA
- h2d_sector_count  in  16  sector count
- read_crc_fail  in  1  host data FIS CRC error (1 cycle)
- remote_abort  in  1  host aborted a transmitted FIS (1 cycle)
- of_strobe  in  1  one host data word consumed
- send_reg_stb  out  1  send D2H register FIS (1 cycle)
- send_dma_act_stb  out  1  send DMA activate (1 cycle)
- send_data_stb  out  1  send data FIS (1 cycle)
- data_fis_words  out  12  word count of the data FIS being sent
- d2h_status  out  8  status field
- d2h_error  out  8  error field
- d2h_lba  out  48  echoed LBA
- d2h_sector_count  out  16  echoed count
- remaining  out  17  sectors still to transfer
- cl_state  out  4  state encoding
- busy  out  1  state != IDLE

Behaviour:
- Reset values:
  - state = SLEEP_START; all strobes 0.
  - data_fis_words = 0; remaining = 0.
  - d2h_status = 8'h50; d2h_error = 8'h01; d2h_lba = 1; d2h_sector_count = 1.
  - Internal word counter = 0; error flag = 0.
- States: SLEEP_START=0, SEND_DIAG=1, IDLE=2, DMA_ACT=3, WRITE_DATA=4, READ_SEND=5, READ_WAIT=6, SEND_STATUS=7. Any other encoding -> SLEEP_START.
- SLEEP_START: count SLEEP_LENGTH cycles, then go to SEND_DIAG.
- SEND_DIAG: pulse send_reg_stb with status 8'h50 and error 8'h01, then go to IDLE.
- IDLE: on h2d_reg_stb with h2d_cmd_bit=1:
  - Latch d2h_lba and d2h_sector_count.
  - Clear the error flag.
  - Load remaining:
    - 48-bit commands (0x25, 0x35): count 0 -> 65536.
    - 28-bit commands (0xC8, 0xCA): use low 8 bits of count; 0 -> 256.
  - 0x25 / 0xC8 -> READ_SEND. 0x35 / 0xCA -> DMA_ACT.
  - Other command -> SEND_STATUS with status 8'h51, error 8'h04.
  - h2d_reg_stb with h2d_cmd_bit=0 is ignored.
- chunk = min(remaining, BURST_SECTORS). chunk_words = chunk * SECTOR_WORDS.
- DMA_ACT: wait for transport_layer_ready, then pulse send_dma_act_stb, clear the word counter, go to WRITE_DATA.
- WRITE_DATA:
  - Each of_strobe increments the word counter.
  - On h2d_data_stb:
    - word count != chunk_words, or read_crc_fail seen during the FIS -> set error, go to SEND_STATUS.
    - Otherwise remaining -= chunk; if the new remaining = 0 -> SEND_STATUS, else -> DMA_ACT.
  - of_strobe in the same cycle as h2d_data_stb is counted before the compare.
- READ_SEND: wait for transport_layer_ready, then pulse send_data_stb with data_fis_words = chunk_words (held until the next load), remaining -= chunk, go to READ_WAIT.
- READ_WAIT:
  - Wait for transport_layer_ready to fall and then rise again (two-phase tracking).
  - remote_abort seen in this state -> set error, go to SEND_STATUS.
  - Otherwise, if remaining = 0 -> SEND_STATUS, else -> READ_SEND.
- SEND_STATUS:
  - Wait for transport_layer_ready, then pulse send_reg_stb and go to IDLE.
  - Fields: status 8'h50 / error 8'h00 on success; status 8'h51 / error 8'h84 (ICRC|ABRT) on error.
- Soft reset: h2d_control[2]=1 in any state forces SLEEP_START and clears the sleep counter and remaining. It has priority over all other transitions; strobes are 0 that cycle.
- Strobes are single-cycle and default to 0 each cycle. At most one strobe is asserted per cycle.

Test Plan:
- Power-up: release rst, idle transport -> send_reg_stb pulse at cycle 101 or 102, status 8'h50, error 8'h01; busy falls.
- WRITE DMA EXT, count 20, BURST_SECTORS 16:
  - Stimulus: 2048 of_strobes + h2d_data_stb, then 512 of_strobes + h2d_data_stb.
  - Response: two DMA activates, remaining 20 -> 4 -> 0, final status 8'h50 / error 8'h00.
- READ DMA (0xC8), count 0 -> 256 sectors: 16 send_data_stb pulses, each with data_fis_words = 2048, then status 8'h50.
- Write with 2047 words before h2d_data_stb -> status 8'h51, error 8'h84; no further DMA activate.
- Command 0xEC -> status 8'h51, error 8'h04. remote_abort mid-read -> status 8'h51 / 8'h84, remaining nonzero.
- SRST asserted mid-WRITE_DATA -> state 0 next cycle, remaining 0, diagnostic FIS repeated after SLEEP_LENGTH.
